alu_issue_stage: RTL
====================

# alu_issue_stage

Registered issue stage that sits between decode and `alu_32bit` in the RV32I execute path. Per instruction, it decodes opcode, funct3 and funct7[5] into the 5-bit ALU operation code and selects the two ALU operands. It passes the result through a 2-entry valid/ready skid buffer, so `in_ready` is a register output and full throughput is kept under back-pressure. Illegal encodings are flagged and forwarded, never dropped.

## Interface
- `XLEN`, 32, operand width
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous active-low reset. Assertion is asynchronous; release is synchronous to `clk`.
- `flush` input 1: synchronous pipeline kill
- `in_valid` input 1: upstream has an instruction
- `in_ready` output 1: stage can accept this cycle
- `opcode` input 7: instr[6:0]
- `funct3` input 3: instr[14:12]
- `funct7_5` input 1: instr[30]
- `pc` input XLEN: instruction address
- `rs1_data` input XLEN: register operand 1
- `rs2_data` input XLEN: register operand 2
- `imm` input XLEN: sign-extended immediate from decode
- `out_valid` output 1: ALU request valid
- `out_ready` input 1: ALU/execute consumer accepts
- `alu_control` output 5: `ALU_*` encoding from define.sv
- `alu_a` output XLEN: ALU operand a
- `alu_b` output XLEN: ALU operand b
- `illegal` output 1: the issued instruction is undecodable

## Operation
- Accept: `in_valid && in_ready`. Issue: `out_valid && out_ready`.
- Decode to {control, a, b}:
  - OP (0110011):
    - a=rs1, b=rs2
    - funct3 000 selects ADD, or SUB if funct7_5=1
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (by funct7_5), 110 OR, 111 AND
    - funct7_5=1 with funct3 other than 000 or 101 is illegal.
  - OP-IMM (0010011): a=rs1, b=imm, same funct3 map.
    - funct3 000 is always ADD; funct7_5 is ignored.
    - funct3 001 with funct7_5=1 is illegal.
  - LUI (0110111): a=0, b=imm, ADD.
  - AUIPC (0010111): a=pc, b=imm, ADD.
  - LOAD (0000011) and STORE (0100011): a=rs1, b=imm, ADD.
  - JAL (1101111) and JALR (1100111): a=pc, b=4, ADD (link value).
  - BRANCH (1100011): a=rs1, b=rs2.
    - funct3 000/001 select SUB.
    - 100/101 select SLT.
    - 110/111 select SLTU.
    - 010/011 are illegal.
  - Any other opcode is illegal.
- Illegal instructions issue with `illegal`=1, control=ADD, a=b=0.
- Buffer: main register (M) drives the outputs; skid register (S) holds one overflow entry.
  - Accept while M is empty, or while M issues this cycle: the new entry loads M.
  - Accept while M is full and stalled: the new entry loads S.
  - When M issues and S is full: S moves to M.
  - `in_ready` is registered as `!S.valid`. It deasserts the cycle after S fills, so at most 2 entries are in flight.
- Ordering is strictly FIFO. There is no duplication or loss except on flush.
- `flush`: next edge clears M.valid and S.valid.
  - Flush overrides a simultaneous accept; that input is consumed and discarded.
  - Flush overrides a simultaneous issue; the issue still counts for the consumer that saw it.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=1, `illegal`=0
  - `alu_a`=0, `alu_b`=0, `alu_control`=`ALU_ADD`
  - S empty
- Latency: an accept at edge N gives `out_valid` with the decoded fields after edge N, visible in cycle N+1.
- Throughput is 1 instruction/cycle while `out_ready`=1.
- Output fields stay stable while `out_valid && !out_ready`.
- Reset asserted mid-operation discards both entries immediately, asynchronously.
- After `out_ready` deasserts, one further accept is possible (into S). `in_ready` falls the cycle after.
- When `out_ready` rises with S full: M issues, S moves to M, and `in_ready` rises on the same edge. The next accept can occur in the following cycle.

## Test plan
- R-type stream, `out_ready`=1:
  - Stimulus: ADD rs1=5, rs2=7, then SUB funct7_5=1 rs1=5, rs2=7, then SRA rs1=0x80000000, rs2=4, on consecutive cycles.
  - Required: three back-to-back issues with {ADD,5,7}, {SUB,5,7}, {SRA,0x80000000,4}, each 1 cycle after its accept.
- Immediate and PC forms:
  - LUI imm=0x12345000 gives {ADD, 0, 0x12345000}.
  - AUIPC pc=0x100, imm=0x2000 gives {ADD, 0x100, 0x2000}.
  - JAL pc=0x40 gives {ADD, 0x40, 4}.
- Back-pressure, 4-instruction stream (A, B, C, D):
  - Stimulus: `out_ready`=0 after A is in M.
  - Required: B is accepted into S and `in_ready` falls; C is held upstream.
  - Stimulus: raise `out_ready`.
  - Required: issue order A, B, C, D with no gaps once unstalled, and fields are stable during the stall.
- Illegal decode:
  - Opcode 0x7F, BRANCH funct3=010, and OP funct3=100 with funct7_5=1 each give `illegal`=1, {ADD,0,0}.
  - A following legal ADDI gives `illegal`=0.
- Flush and reset:
  - Stimulus: fill M and S, then pulse `flush` together with `in_valid`.
  - Required: next cycle `out_valid`=0, `in_ready`=1, and the flushed input never issues.
  - Stimulus: assert `rst_n` low mid-stall, between clock edges.
  - Required: `out_valid` drops immediately, and all outputs take their reset values.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I issue stage: decodes opcode/funct3/funct7[5] into an ALU op plus operands,
// and buffers the result in a 2-entry skid buffer with a registered in_ready.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      alu_control,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic            illegal
);

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic            ill;
        logic [4:0]      ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } entry_t;

    localparam entry_t IDLE_ENTRY    = '{ill: 1'b0, ctrl: ALU_ADD, a: '0, b: '0};
    localparam entry_t ILLEGAL_ENTRY = '{ill: 1'b1, ctrl: ALU_ADD, a: '0, b: '0};

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    entry_t dec;
    entry_t m_q, m_d, s_q, s_d;
    logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d, in_ready_q, in_ready_d;
    logic   accept, issue;

    always_comb begin
        dec = IDLE_ENTRY;
        case (opcode)
            OPC_OP: begin
                dec.a    = rs1_data;
                dec.b    = rs2_data;
                dec.ctrl = arith_op(funct3, funct7_5);
                dec.ill  = funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101);
            end
            OPC_OP_IMM: begin
                dec.a    = rs1_data;
                dec.b    = imm;
                dec.ctrl = arith_op(funct3, funct7_5 && (funct3 == 3'b101));
                dec.ill  = funct7_5 && (funct3 == 3'b001);
            end
            OPC_LUI: dec.b = imm;
            OPC_AUIPC: begin
                dec.a = pc;
                dec.b = imm;
            end
            OPC_LOAD, OPC_STORE: begin
                dec.a = rs1_data;
                dec.b = imm;
            end
            OPC_JAL, OPC_JALR: begin
                dec.a = pc;
                dec.b = XLEN'(4);
            end
            OPC_BRANCH: begin
                dec.a = rs1_data;
                dec.b = rs2_data;
                case (funct3[2:1])
                    2'b00:   dec.ctrl = ALU_SUB;
                    2'b01:   dec.ill  = 1'b1;
                    2'b10:   dec.ctrl = ALU_SLT;
                    default: dec.ctrl = ALU_SLTU;
                endcase
            end
            default: dec.ill = 1'b1;
        endcase
        if (dec.ill) begin
            dec = ILLEGAL_ENTRY;
        end
    end

    assign accept = in_valid && in_ready_q;
    assign issue  = m_valid_q && out_ready;

    // S can only be occupied while M is, so in_ready_q == !s_valid_q and an accept never meets a full S
    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || issue) begin
            if (s_valid_q) begin
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_d       = dec;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_d       = dec;
            s_valid_d = 1'b1;
        end
        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q        <= IDLE_ENTRY;
            s_q        <= IDLE_ENTRY;
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = m_valid_q;
    assign alu_control = m_q.ctrl;
    assign alu_a       = m_q.a;
    assign alu_b       = m_q.b;
    assign illegal     = m_q.ill;

endmodule
